mgmt_gpio_bank: RTL and testbench

//  Multi-pin management GPIO bank, the N-wide successor to the single mgmt GPIO of mgmt_soc.

---
 rtl/mgmt_gpio_bank.sv | 170 +++++++++++++++++
 tb/tb_mgmt_gpio_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mgmt_gpio_bank.sv
// Management GPIO bank: register-mapped pad outputs and enables, synchronised inputs,
// sticky edge interrupts and a per-pin hardware blink driven by a shared prescaler.
module mgmt_gpio_bank #(
   parameter int NPINS = 8,
   parameter int DIV_W = 16
) (
   input  logic             core_clk,
   input  logic             RST,
   input  logic             bus_sel,
   input  logic             bus_we,
   input  logic [2:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata,
   output logic             bus_ack,
   input  logic [NPINS-1:0] gpio_in,
   output logic [NPINS-1:0] gpio_out,
   output logic [NPINS-1:0] gpio_oeb,
   output logic             irq
);

   typedef enum logic [2:0] {
      A_DATA_OUT   = 3'd0,
      A_OEB        = 3'd1,
      A_DATA_IN    = 3'd2,
      A_RISE_EN    = 3'd3,
      A_FALL_EN    = 3'd4,
      A_IRQ_STATUS = 3'd5,
      A_BLINK_EN   = 3'd6,
      A_BLINK_DIV  = 3'd7
   } reg_addr_e;

   reg_addr_e        addr;
   logic             wr, rd;
   logic             unused_wdata;

   logic [NPINS-1:0] data_out_q, data_out_d, oeb_q, oeb_d;
   logic [NPINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [NPINS-1:0] status_q, status_d, blink_en_q, blink_en_d;
   logic [DIV_W-1:0] blink_div_q, blink_div_d, presc_q, presc_d;
   logic             phase_q, phase_d, primed_q, primed_d;
   logic [NPINS-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [NPINS-1:0] rise, fall, edge_set, w1c_mask;
   logic             ack_q, ack_d, irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [NPINS-1:0] gpio_out_q, gpio_out_d, gpio_oeb_q, gpio_oeb_d;

   assign addr         = reg_addr_e'(bus_addr);
   assign wr           = bus_sel & bus_we;
   assign rd           = bus_sel & ~bus_we;
   assign unused_wdata = ^bus_wdata;

   always_comb begin
      // NOTE: every _d defaults to its _q (or a constant) first, so no branch can infer a latch.
      data_out_d  = data_out_q;
      oeb_d       = oeb_q;
      rise_en_d   = rise_en_q;
      fall_en_d   = fall_en_q;
      blink_en_d  = blink_en_q;
      blink_div_d = blink_div_q;
      s1_d        = gpio_in;
      s2_d        = s1_q;
      s3_d        = s2_q;
      primed_d    = 1'b1;
      ack_d       = bus_sel;
      rdata_d     = '0;
      irq_d       = |status_q;

      if (rd) begin
         case (addr)
            A_DATA_OUT:   rdata_d = 32'(data_out_q);
            A_OEB:        rdata_d = 32'(oeb_q);
            A_DATA_IN:    rdata_d = 32'(s2_q);
            A_RISE_EN:    rdata_d = 32'(rise_en_q);
            A_FALL_EN:    rdata_d = 32'(fall_en_q);
            A_IRQ_STATUS: rdata_d = 32'(status_q);
            A_BLINK_EN:   rdata_d = 32'(blink_en_q);
            A_BLINK_DIV:  rdata_d = 32'(blink_div_q);
            default:      rdata_d = '0;
         endcase
      end

      // A new edge beats a same-cycle W1C on the same bit.
      rise     = s2_q & ~s3_q;
      fall     = ~s2_q & s3_q;
      edge_set = primed_q ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
      w1c_mask = (wr && addr == A_IRQ_STATUS) ? bus_wdata[NPINS-1:0] : '0;
      status_d = (status_q & ~w1c_mask) | edge_set;

      if (wr) begin
         case (addr)
            A_DATA_OUT:  data_out_d  = bus_wdata[NPINS-1:0];
            A_OEB:       oeb_d       = bus_wdata[NPINS-1:0];
            A_RISE_EN:   rise_en_d   = bus_wdata[NPINS-1:0];
            A_FALL_EN:   fall_en_d   = bus_wdata[NPINS-1:0];
            A_BLINK_EN:  blink_en_d  = bus_wdata[NPINS-1:0];
            A_BLINK_DIV: blink_div_d = bus_wdata[DIV_W-1:0];
            default:     ;
         endcase
      end

      if (wr && addr == A_BLINK_DIV) begin
         presc_d = '0;
         phase_d = 1'b0;
      end else if (|blink_en_q) begin
         if (presc_q == blink_div_q) begin
            presc_d = '0;
            phase_d = ~phase_q;
         end else begin
            presc_d = presc_q + DIV_W'(1);
            phase_d = phase_q;
         end
      end else begin
         presc_d = '0;
         phase_d = 1'b0;
      end

      // Outputs follow next-state register values so the pads match the registers with no lag.
      gpio_out_d = (blink_en_d & {NPINS{phase_d}}) | (data_out_d & ~blink_en_d);
      gpio_oeb_d = oeb_d;
   end

   always_ff @(posedge core_clk) begin
      if (RST) begin
         data_out_q  <= '0;
         oeb_q       <= '1;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         status_q    <= '0;
         blink_en_q  <= '0;
         blink_div_q <= '0;
         presc_q     <= '0;
         phase_q     <= 1'b0;
         primed_q    <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         irq_q       <= 1'b0;
         gpio_out_q  <= '0;
         gpio_oeb_q  <= '1;
      end else begin
         data_out_q  <= data_out_d;
         oeb_q       <= oeb_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         status_q    <= status_d;
         blink_en_q  <= blink_en_d;
         blink_div_q <= blink_div_d;
         presc_q     <= presc_d;
         phase_q     <= phase_d;
         primed_q    <= primed_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
         gpio_out_q  <= gpio_out_d;
         gpio_oeb_q  <= gpio_oeb_d;
      end
   end

   assign bus_ack   = ack_q;
   assign bus_rdata = rdata_q;
   assign irq       = irq_q;
   assign gpio_out  = gpio_out_q;
   assign gpio_oeb  = gpio_oeb_q;

endmodule

// File: tb/tb_mgmt_gpio_bank.sv
// Scoreboard bench for mgmt_gpio_bank: directed scenarios then random bus/pad traffic,
// checked against a register-level model of the bank.
module tb_mgmt_gpio_bank;
   localparam int NPINS = 8;

   logic             core_clk = 1'b0;
   logic             RST = 1'b1;
   logic             bus_sel = 1'b0, bus_we = 1'b0;
   logic [2:0]       bus_addr = '0;
   logic [31:0]      bus_wdata = '0;
   logic [31:0]      bus_rdata;
   logic             bus_ack;
   logic [NPINS-1:0] gpio_in = '0;
   logic [NPINS-1:0] gpio_out, gpio_oeb;
   logic             irq;

   mgmt_gpio_bank #(.NPINS(NPINS), .DIV_W(16)) dut (
      .core_clk(core_clk), .RST(RST), .bus_sel(bus_sel), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .gpio_oeb(gpio_oeb), .irq(irq)
   );

   always #5 core_clk = ~core_clk;

   typedef struct { logic is_rd; logic [31:0] data; } resp_t;
   resp_t rq[$];

   int   n_checks = 0, n_fail = 0;
   logic chk_en = 1'b0;
   logic [7:0] gin = '0;

   // Reference model: register file, pad sample history, blink cycle count.
   logic [7:0] m_dout, m_oeb, m_rise, m_fall, m_stat, m_ben;
   int         m_div, m_bk, since_rst;
   logic [7:0] pin_hist[$];
   logic       m_irq;
   logic [7:0] exp_out, exp_oeb;
   logic       exp_irq, exp_ack;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_value(input int a, input logic [7:0] s2);
      case (a)
         0: return 32'(m_dout);
         1: return 32'(m_oeb);
         2: return 32'(s2);
         3: return 32'(m_rise);
         4: return 32'(m_fall);
         5: return 32'(m_stat);
         6: return 32'(m_ben);
         default: return 32'(m_div);
      endcase
   endfunction

   task automatic model_edge(input logic sel, input logic we, input int a,
                             input logic [31:0] wd, input logic rst);
      logic [7:0] s2, s3, set, clr;
      logic       irq_next, phase;
      if (rst) begin
         m_dout = 0; m_oeb = 8'hFF; m_rise = 0; m_fall = 0; m_stat = 0; m_ben = 0;
         m_div = 0; m_bk = 0; since_rst = 0; m_irq = 0; exp_ack = 0;
         pin_hist = '{8'h00, 8'h00, 8'h00};
      end else begin
         s2 = pin_hist[1];
         s3 = pin_hist[2];
         set = (since_rst >= 1) ? ((s2 & ~s3 & m_rise) | (~s2 & s3 & m_fall)) : 8'h00;
         irq_next = (m_stat != 0);
         if (sel && !we) rq.push_back('{1'b1, rd_value(a, s2)});
         else if (sel)   rq.push_back('{1'b0, 32'h0});
         if (sel && we && a == 7) m_bk = 0;
         else if (m_ben == 0)     m_bk = 0;
         else                     m_bk++;
         clr = (sel && we && a == 5) ? wd[7:0] : 8'h00;
         m_stat = (m_stat & ~clr) | set;
         if (sel && we) begin
            case (a)
               0: m_dout = wd[7:0];
               1: m_oeb  = wd[7:0];
               3: m_rise = wd[7:0];
               4: m_fall = wd[7:0];
               6: m_ben  = wd[7:0];
               7: m_div  = int'(wd[15:0]);
               default: ;
            endcase
         end
         pin_hist.push_front(gin);
         void'(pin_hist.pop_back());
         since_rst++;
         m_irq   = irq_next;
         exp_ack = sel;
      end
      phase   = ((m_bk / (m_div + 1)) % 2) == 1;
      exp_out = (m_ben & {8{phase}}) | (m_dout & ~m_ben);
      exp_oeb = m_oeb;
      exp_irq = m_irq;
   endtask

   task automatic cycle(input logic sel, input logic we, input int a,
                        input logic [31:0] wd, input logic rst);
      @(negedge core_clk);
      RST = rst; bus_sel = sel; bus_we = we; bus_addr = 3'(a); bus_wdata = wd;
      gpio_in = gin;
      model_edge(sel, we, a, wd, rst);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
   endtask
   task automatic wr(input int a, input logic [31:0] d); cycle(1'b1, 1'b1, a, d, 1'b0); endtask
   task automatic rd(input int a); cycle(1'b1, 1'b0, a, 32'h0, 1'b0); endtask
   task automatic reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
   endtask

   // Monitor: compares pads and irq every cycle, and pops the scoreboard on each ack.
   always @(posedge core_clk) begin
      resp_t r;
      #1;
      if (chk_en) begin
         check("gpio_out", 32'(gpio_out), 32'(exp_out));
         check("gpio_oeb", 32'(gpio_oeb), 32'(exp_oeb));
         check("irq", 32'(irq), 32'(exp_irq));
         check("bus_ack", 32'(bus_ack), 32'(exp_ack));
         if (bus_ack) begin
            if (rq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
            end else begin
               r = rq.pop_front();
               if (r.is_rd) check("bus_rdata", bus_rdata, r.data);
            end
         end
      end
   end

   initial begin
      gin = 8'h00;
      reset(1);
      chk_en = 1'b1;
      reset(2);
      rd(1);
      idle(2);

      wr(0, 32'hA5); wr(1, 32'h00); rd(0); idle(2);

      wr(3, 32'h01); gin = 8'h01; idle(5); rd(5); idle(1); wr(5, 32'h01); idle(3);

      wr(4, 32'h80);
      gin = 8'h81; idle(4);
      gin = 8'h01; idle(5);
      gin = 8'h81; idle(4);
      gin = 8'h01; idle(2);
      wr(5, 32'h80);
      idle(2); rd(5); idle(2);

      wr(7, 32'h4); wr(6, 32'h02); idle(25); rd(0); wr(6, 32'h0); idle(3);

      gin = 8'hFF;
      reset(3);
      idle(3); wr(3, 32'hFF); idle(4); rd(5); rd(2); idle(2);

      cycle(1'b1, 1'b1, 0, 32'h3C, 1'b1);
      idle(1); rd(0); idle(2);

      for (int i = 0; i < 600; i++) begin
         int op, a;
         logic [31:0] d;
         if ($urandom_range(0, 3) == 0) gin = gin ^ 8'($urandom);
         op = $urandom_range(0, 99);
         a  = $urandom_range(0, 7);
         d  = (a == 7) ? 32'($urandom_range(0, 5)) : $urandom;
         if (op < 1)       cycle(1'b1, 1'b1, a, d, 1'b1);
         else if (op < 40) idle(1);
         else if (op < 70) wr(a, d);
         else              rd(a);
      end

      idle(4);
      check("scoreboard_drained", 32'(rq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
